// File: rtl/regfile_dump_reader_pkg.sv
// Shared types and constants for the register-file dump reader.
// Widths match the RegisterFile read port it sits on.
package regfile_dump_reader_pkg;

    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;

    typedef logic [ADDR_W-1:0] reg_idx_t;
    typedef logic [DATA_W-1:0] reg_data_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } state_e;

    // A request is usable only when it is non-empty and stays inside the file.
    function automatic logic range_ok(input reg_idx_t first_idx, input reg_idx_t last_idx);
        return (first_idx <= last_idx) && (int'(last_idx) < NUM_REGS);
    endfunction

endpackage

// File: rtl/regfile_dump_reader_if.sv
// Dump beat stream: one register value plus its index per beat.
interface regfile_dump_reader_if;
    import regfile_dump_reader_pkg::*;

    // Valid/ready: a beat transfers on a rising clk edge where dump_valid and
    // dump_ready are both high; while dump_valid is high and dump_ready is low,
    // dump_data and dump_index hold steady. dump_ready alone has no effect.
    logic      dump_valid;
    logic      dump_ready;
    reg_data_t dump_data;
    reg_idx_t  dump_index;

    modport master (
        output dump_valid,
        output dump_data,
        output dump_index,
        input  dump_ready
    );

    modport slave (
        input  dump_valid,
        input  dump_data,
        input  dump_index,
        output dump_ready
    );

endinterface

// File: rtl/regfile_dump_range_counter.sv
// Holds the current and final register index of a dump and flags the last one.
module regfile_dump_range_counter
    import regfile_dump_reader_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     load,
    input  logic     advance,
    input  reg_idx_t first_reg,
    input  reg_idx_t last_reg,
    output reg_idx_t cur,
    output logic     is_last
);

    reg_idx_t cur_q, cur_d;
    reg_idx_t last_q, last_d;

    always_comb begin
        cur_d  = cur_q;
        last_d = last_q;
        if (load) begin
            cur_d  = first_reg;
            last_d = last_reg;
        end else if (advance) begin
            cur_d = cur_q + reg_idx_t'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_q  <= '0;
            last_q <= '0;
        end else begin
            cur_q  <= cur_d;
            last_q <= last_d;
        end
    end

    // Compared before incrementing, so a dump ending at the top index never wraps.
    assign cur     = cur_q;
    assign is_last = (cur_q == last_q);

endmodule

// File: rtl/regfile_dump_reader.sv
// Walks an inclusive register range on the RegisterFile read port and streams
// each value with its index as one valid/ready beat.
module regfile_dump_reader
    import regfile_dump_reader_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         abort,
    input  reg_idx_t                     first_reg,
    input  reg_idx_t                     last_reg,
    output reg_idx_t                     rf_read_register,
    input  reg_data_t                    rf_read_data,
    regfile_dump_reader_if.master        dump,
    output logic                         busy,
    output logic                         done,
    output logic                         err,
    output state_e                       dbg_state
);

    state_e    state_q, state_d;
    logic      err_q, err_d;
    reg_data_t data_q, data_d;
    reg_idx_t  index_q, index_d;

    logic     load;
    logic     advance;
    logic     capture;
    reg_idx_t cur;
    logic     is_last;

    regfile_dump_range_counter u_range (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .advance   (advance),
        .first_reg (first_reg),
        .last_reg  (last_reg),
        .cur       (cur),
        .is_last   (is_last)
    );

    always_comb begin
        state_d = state_q;
        err_d   = 1'b0;
        load    = 1'b0;
        advance = 1'b0;
        capture = 1'b0;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (range_ok(first_reg, last_reg)) begin
                            load    = 1'b1;
                            state_d = READ;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                READ: begin
                    capture = 1'b1;
                    state_d = SEND;
                end
                SEND: begin
                    if (dump.dump_ready) begin
                        if (is_last) begin
                            state_d = DONE;
                        end else begin
                            advance = 1'b1;
                            state_d = READ;
                        end
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // The read port is combinational, so the value for cur is sampled in READ.
    always_comb begin
        data_d  = data_q;
        index_d = index_q;
        if (capture) begin
            data_d  = rf_read_data;
            index_d = cur;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            err_q   <= 1'b0;
            data_q  <= '0;
            index_q <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            data_q  <= data_d;
            index_q <= index_d;
        end
    end

    assign busy             = (state_q == READ) || (state_q == SEND);
    assign done             = (state_q == DONE);
    assign err              = err_q;
    assign rf_read_register = busy ? cur : '0;
    assign dump.dump_valid  = (state_q == SEND);
    assign dump.dump_data   = data_q;
    assign dump.dump_index  = index_q;
    assign dbg_state        = state_q;

endmodule
